sd_spi_arbiter: RTL and testbench
=================================

SD_SPI_ARBITER -- requirements
Module: sd_spi_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 8: spi_cs_n-high idle cycles between two ownerships.
REQ-002 Parameter TIMEOUT, default 65535: idle-owner cycles before forced release.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_state  input  1  reset, asynchronous, active-high.
REQ-005 req0/req1  input  1  requester N wants SPI ownership (level).
REQ-006 gnt0/gnt1  output  1  requester N currently owns SPI.
REQ-007 tx_valid0/tx_valid1  input  1  requester N offers a byte.
REQ-008 tx_data0/tx_data1  input  8  byte to transmit.
REQ-009 tx_ready0/tx_ready1  output  1  byte accepted this cycle.
REQ-010 rx_valid0/rx_valid1  output  1  one-cycle pulse; received byte for requester N.
REQ-011 rx_data0/rx_data1  output  8  received byte.
REQ-012 abort0/abort1  output  1  one-cycle pulse; ownership revoked.
REQ-013 spi_tx_valid  output  1, spi_tx_data  output  8: request to byte engine.
REQ-014 spi_tx_ready  input  1: byte engine accepts.
REQ-015 spi_rx_valid  input  1, spi_rx_data  input  8: exactly one per accepted byte.
REQ-016 spi_cs_n  output  1: card chip select, active low.
REQ-017 sd_present  input  1: synchronised card-detect level, high = card inserted.

Function
REQ-018 FSM states IDLE, OWN, GAP; at most one gnt high at any time.
REQ-019 IDLE: sd_present=1 and any req high -> OWN next cycle; winner's gnt=1, spi_cs_n=0 same cycle.
REQ-020 Both req high in IDLE: grant the requester not granted last; first grant after reset goes to requester 0.
REQ-021 OWN: spi_tx_valid/spi_tx_data = owner's tx_valid/tx_data, gated by inflight=0; owner tx_ready = spi_tx_ready & ~inflight; non-owner tx_ready=0.
REQ-022 inflight sets on spi_tx_valid&spi_tx_ready, clears on spi_rx_valid; at most one byte outstanding.
REQ-023 spi_rx_valid routes combinationally to owner's rx_valid/rx_data; non-owner rx_valid=0.
REQ-024 Owner drops req: remain OWN until inflight=0, then enter GAP; gnt low and spi_cs_n high on GAP entry.
REQ-025 GAP: spi_cs_n=1, no gnt, down-counter GAP_CYCLES to 0, then IDLE; requests ignored during GAP.
REQ-026 sd_present falls in OWN: next cycle owner abort pulses, gnt=0, spi_cs_n=1, state GAP; pending spi_rx_valid dropped, inflight cleared.
REQ-027 Idle counter counts OWN cycles with inflight=0 and no tx handshake; reaching TIMEOUT -> same behaviour as REQ-026.
REQ-028 Idle counter clears on every tx handshake and on OWN entry; width clog2(TIMEOUT+1).
REQ-029 sd_present=0 in IDLE: no grants issued; req held stays pending.
REQ-030 spi_rx_valid arriving while not OWN or inflight=0: discarded, no rx_valid pulse.

Reset
REQ-031 rst_state asserted: state IDLE, gnt0=gnt1=0, spi_cs_n=1, spi_tx_valid=0, rx_valid*=0, abort*=0, tx_ready*=0, inflight=0, counters 0, last-grant = requester 1.
REQ-032 Reset mid-transfer: no abort pulse, engine byte discarded; outputs reach reset values asynchronously.

Structure
REQ-033 FSM state encoding and default GAP_CYCLES/TIMEOUT constants in shared package sd_pkg.
REQ-034 Single flat module; no sub-modules.

Verification
REQ-035 req0=1, sd_present=1 -> gnt0=1, spi_cs_n=0 one cycle later; byte 0xFF echoed as rx_data0=0xFF.
REQ-036 req0,req1 same cycle after reset -> gnt0 first; req0 drop -> 8 CS-high cycles -> gnt1.
REQ-037 Owner drops req with byte inflight -> gnt held until spi_rx_valid, then GAP.
REQ-038 sd_present falls mid-byte -> abort0 one-cycle pulse, spi_cs_n=1 next cycle, late spi_rx_valid gives no rx_valid0.
REQ-039 TIMEOUT=16, owner idle 16 cycles -> abort pulse, gnt=0.
REQ-040 rst_state pulse while OWN -> gnt0=0, spi_cs_n=1 immediately; next grant to requester 0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared state encoding and default timing constants for the SD card SPI arbiter.
package sd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } sd_state_e;

  localparam int SD_GAP_CYCLES = 8;
  localparam int SD_TIMEOUT    = 65535;

  // Bits needed to hold the values 0..max_val, never less than one.
  function automatic int sd_cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sd_spi_arbiter.sv
// Two-requester ownership arbiter for the SD card SPI byte engine; gnt/spi_cs_n follow state one cycle after a request.
// Byte path is combinational with one byte outstanding; owner tx_ready mirrors engine ready while nothing is inflight.
module sd_spi_arbiter
  import sd_pkg::*;
#(
  parameter int GAP_CYCLES = SD_GAP_CYCLES,
  parameter int TIMEOUT    = SD_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_state,
  input  logic       req0,
  input  logic       req1,
  output logic       gnt0,
  output logic       gnt1,
  input  logic       tx_valid0,
  input  logic       tx_valid1,
  input  logic [7:0] tx_data0,
  input  logic [7:0] tx_data1,
  output logic       tx_ready0,
  output logic       tx_ready1,
  output logic       rx_valid0,
  output logic       rx_valid1,
  output logic [7:0] rx_data0,
  output logic [7:0] rx_data1,
  output logic       abort0,
  output logic       abort1,
  output logic       spi_tx_valid,
  output logic [7:0] spi_tx_data,
  input  logic       spi_tx_ready,
  input  logic       spi_rx_valid,
  input  logic [7:0] spi_rx_data,
  output logic       spi_cs_n,
  input  logic       sd_present
);

  localparam int GAP_W  = sd_cnt_width(GAP_CYCLES);
  localparam int IDLE_W = sd_cnt_width(TIMEOUT);
  // GAP holds GAP_CYCLES-1 cycles; the IDLE arbitration cycle completes the cs-high gap.
  localparam logic [GAP_W-1:0]  GAP_LOAD = (GAP_CYCLES > 1) ? GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);

  sd_state_e         r_state;
  sd_state_e         w_state_nxt;
  logic              r_owner;
  logic              w_owner_nxt;
  logic              r_last;
  logic              w_last_nxt;
  logic              r_inflight;
  logic              w_inflight_nxt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [GAP_W-1:0]  w_gap_cnt_nxt;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic [IDLE_W-1:0] w_idle_cnt_nxt;
  logic              r_abort0;
  logic              r_abort1;
  logic              w_abort0_nxt;
  logic              w_abort1_nxt;

  logic              w_own;
  logic              w_own_req;
  logic              w_own_txv;
  logic [7:0]        w_own_txd;
  logic              w_tx_hs;
  logic              w_rx_take;
  logic              w_inflight_upd;
  logic              w_idle_cyc;
  logic [IDLE_W-1:0] w_idle_inc;
  logic              w_timeout;
  logic              w_kill;
  logic              w_pick;

  assign w_own     = (r_state == ST_OWN);
  assign w_own_req = r_owner ? req1 : req0;
  assign w_own_txv = r_owner ? tx_valid1 : tx_valid0;
  assign w_own_txd = r_owner ? tx_data1 : tx_data0;

  assign spi_tx_valid   = w_own & ~r_inflight & w_own_txv;
  assign spi_tx_data    = w_own ? w_own_txd : 8'h00;
  assign w_tx_hs        = spi_tx_valid & spi_tx_ready;
  assign w_rx_take      = w_own & r_inflight & spi_rx_valid;
  assign w_inflight_upd = w_tx_hs | (r_inflight & ~spi_rx_valid);

  assign w_idle_cyc = w_own & ~r_inflight & ~w_tx_hs;
  assign w_idle_inc = r_idle_cnt + 1'b1;
  assign w_timeout  = w_idle_cyc & (w_idle_inc == IDLE_MAX);
  assign w_kill     = ~sd_present | w_timeout;

  // Round-robin tie break: the requester not granted last time wins.
  assign w_pick = (req0 & req1) ? ~r_last : req1;

  assign gnt0      = w_own & ~r_owner;
  assign gnt1      = w_own & r_owner;
  assign spi_cs_n  = ~w_own;
  assign tx_ready0 = gnt0 & spi_tx_ready & ~r_inflight;
  assign tx_ready1 = gnt1 & spi_tx_ready & ~r_inflight;
  assign rx_valid0 = w_rx_take & ~r_owner;
  assign rx_valid1 = w_rx_take & r_owner;
  assign rx_data0  = rx_valid0 ? spi_rx_data : 8'h00;
  assign rx_data1  = rx_valid1 ? spi_rx_data : 8'h00;
  assign abort0    = r_abort0;
  assign abort1    = r_abort1;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_last_nxt     = r_last;
    w_inflight_nxt = r_inflight;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_idle_cnt_nxt = r_idle_cnt;
    w_abort0_nxt   = 1'b0;
    w_abort1_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_inflight_nxt = 1'b0;
        if (sd_present && (req0 || req1)) begin
          w_state_nxt    = ST_OWN;
          w_owner_nxt    = w_pick;
          w_last_nxt     = w_pick;
          w_idle_cnt_nxt = '0;
        end
      end
      ST_OWN: begin
        w_inflight_nxt = w_inflight_upd;
        if (w_tx_hs) begin
          w_idle_cnt_nxt = '0;
        end else if (w_idle_cyc) begin
          w_idle_cnt_nxt = w_idle_inc;
        end
        if (w_kill) begin
          // Card gone or owner stalled: revoke; any engine reply still due is dropped.
          w_state_nxt    = ST_GAP;
          w_gap_cnt_nxt  = GAP_LOAD;
          w_inflight_nxt = 1'b0;
          w_abort0_nxt   = ~r_owner;
          w_abort1_nxt   = r_owner;
        end else if (!w_own_req && !w_inflight_upd) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = GAP_LOAD;
        end
      end
      ST_GAP: begin
        w_inflight_nxt = 1'b0;
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt   = ST_IDLE;
          w_gap_cnt_nxt = '0;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_inflight_nxt = 1'b0;
        w_gap_cnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_state) begin
    if (rst_state) begin
      r_state    <= ST_IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_inflight <= 1'b0;
      r_gap_cnt  <= '0;
      r_idle_cnt <= '0;
      r_abort0   <= 1'b0;
      r_abort1   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
      r_inflight <= w_inflight_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_abort0   <= w_abort0_nxt;
      r_abort1   <= w_abort1_nxt;
    end
  end

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed bench for sd_spi_arbiter with GAP_CYCLES=8, TIMEOUT=16: a per-cycle vector table plus corner-case sequences.
module tb_sd_spi_arbiter;

  logic       clk = 1'b0;
  logic       rst_state;
  logic       req0, req1, gnt0, gnt1;
  logic       tx_valid0, tx_valid1, tx_ready0, tx_ready1;
  logic [7:0] tx_data0, tx_data1;
  logic       rx_valid0, rx_valid1;
  logic [7:0] rx_data0, rx_data1;
  logic       abort0, abort1;
  logic       spi_tx_valid, spi_tx_ready, spi_rx_valid, spi_cs_n, sd_present;
  logic [7:0] spi_tx_data, spi_rx_data;

  int n_chk  = 0;
  int n_pass = 0;
  int n;

  always #5 clk = ~clk;

  sd_spi_arbiter #(.GAP_CYCLES(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst_state(rst_state),
    .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
    .tx_valid0(tx_valid0), .tx_valid1(tx_valid1),
    .tx_data0(tx_data0), .tx_data1(tx_data1),
    .tx_ready0(tx_ready0), .tx_ready1(tx_ready1),
    .rx_valid0(rx_valid0), .rx_valid1(rx_valid1),
    .rx_data0(rx_data0), .rx_data1(rx_data1),
    .abort0(abort0), .abort1(abort1),
    .spi_tx_valid(spi_tx_valid), .spi_tx_data(spi_tx_data), .spi_tx_ready(spi_tx_ready),
    .spi_rx_valid(spi_rx_valid), .spi_rx_data(spi_rx_data),
    .spi_cs_n(spi_cs_n), .sd_present(sd_present)
  );

  // Bit 0 of every 2-bit field belongs to requester 0.
  typedef struct {
    logic [1:0] req;
    logic       sd;
    logic [1:0] txv;
    logic [7:0] txd0;
    logic [7:0] txd1;
    logic       erdy;
    logic       erxv;
    logic [7:0] erxd;
    logic [1:0] gnt;
    logic       csn;
    logic       stxv;
    logic [7:0] stxd;
    logic [1:0] txr;
    logic [1:0] rxv;
    logic [7:0] rxd0;
    logic [7:0] rxd1;
    logic [1:0] abt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endtask

  task automatic win();
    @(negedge clk);
  endtask

  task automatic clr_in();
    req0 = 1'b0; req1 = 1'b0; sd_present = 1'b1;
    tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_data0 = 8'h00; tx_data1 = 8'h00;
    spi_tx_ready = 1'b0; spi_rx_valid = 1'b0; spi_rx_data = 8'h00;
  endtask

  task automatic apply(input vec_t v);
    req0 = v.req[0]; req1 = v.req[1]; sd_present = v.sd;
    tx_valid0 = v.txv[0]; tx_valid1 = v.txv[1]; tx_data0 = v.txd0; tx_data1 = v.txd1;
    spi_tx_ready = v.erdy; spi_rx_valid = v.erxv; spi_rx_data = v.erxd;
  endtask

  function automatic logic [63:0] exp_pack(input vec_t v);
    return 64'({v.gnt, v.csn, v.stxv, (v.stxv ? v.stxd : 8'h00), v.txr, v.rxv,
                (v.rxv[0] ? v.rxd0 : 8'h00), (v.rxv[1] ? v.rxd1 : 8'h00), v.abt});
  endfunction

  function automatic logic [63:0] got_pack(input vec_t v);
    return 64'({gnt1, gnt0, spi_cs_n, spi_tx_valid, (v.stxv ? spi_tx_data : 8'h00),
                tx_ready1, tx_ready0, rx_valid1, rx_valid0,
                (v.rxv[0] ? rx_data0 : 8'h00), (v.rxv[1] ? rx_data1 : 8'h00), abort1, abort0});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // req  sd   txv   txd0   txd1   erdy  erxv  erxd  | gnt  csn  stxv stxd  txr   rxv   rxd0   rxd1   abt
    tbl.push_back(vec_t'{2'b00, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 8'hFF, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b01, 8'h3C, 8'h00, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b01, 8'h3C, 8'h00, 1'b1, 1'b1, 8'hFF, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b01, 8'hFF, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b01, 8'h3C, 8'h00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 8'h3C, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b11, 1'b1, 2'b11, 8'h3C, 8'h99, 1'b1, 1'b0, 8'h00, 2'b01, 1'b0, 1'b1, 8'h3C, 2'b01, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA5, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 2'b01, 8'hA5, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'hEE, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    for (int k = 0; k < 6; k++)
      tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b11, 8'h11, 8'h5A, 1'b1, 1'b0, 8'h00, 2'b10, 1'b0, 1'b1, 8'h5A, 2'b10, 2'b00, 8'h00, 8'h00, 2'b00});
    tbl.push_back(vec_t'{2'b10, 1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h81, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 2'b10, 8'h00, 8'h81, 2'b00});

    clr_in();
    sd_present = 1'b0;
    rst_state  = 1'b1;
    repeat (2) win();
    #1;
    chk("reset_state", 64'({gnt1, gnt0, spi_cs_n, spi_tx_valid, tx_ready1, tx_ready0, rx_valid1, rx_valid0, abort1, abort0}),
        64'(10'b0010000000));
    rst_state = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      win();
      apply(tbl[i]);
      #1;
      chk($sformatf("row%0d", i), got_pack(tbl[i]), exp_pack(tbl[i]));
    end

    // Owner 1 releases; requester 0 waits out the cs-high gap, sends a byte, then the card is pulled.
    win(); clr_in(); #1;
    chk("A_release_window_gnt1", 64'(gnt1), 64'(1'b1));
    win(); req0 = 1'b1; #1;
    n = 0;
    while (!gnt0 && n < 40) begin
      if (spi_cs_n) n++;
      win(); #1;
    end
    chk("A_cs_high_gap_len", 64'(n), 64'(8));
    tx_valid0 = 1'b1; tx_data0 = 8'h42; spi_tx_ready = 1'b1; #1;
    chk("A_tx_offer", 64'({spi_tx_valid, spi_tx_data, tx_ready0}), 64'({1'b1, 8'h42, 1'b1}));
    win(); tx_valid0 = 1'b0; spi_tx_ready = 1'b0; sd_present = 1'b0; #1;
    chk("A_owner_before_abort", 64'({gnt0, abort0, spi_cs_n}), 64'(3'b100));
    win(); spi_rx_valid = 1'b1; spi_rx_data = 8'h77; #1;
    chk("A_abort_pulse", 64'({abort1, abort0, gnt1, gnt0, spi_cs_n}), 64'(5'b01001));
    chk("A_late_rx_dropped", 64'({rx_valid1, rx_valid0}), 64'(2'b00));
    win(); spi_rx_valid = 1'b0; #1;
    chk("A_abort_one_cycle", 64'({abort1, abort0}), 64'(2'b00));

    // Card absent: requester 0 stays pending with no grant until the card returns.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      win(); #1;
      if (gnt0 || gnt1) n++;
    end
    chk("C_no_grant_card_absent", 64'(n), 64'(0));
    win(); sd_present = 1'b1; #1;
    chk("C_idle_before_grant", 64'({gnt0, spi_cs_n}), 64'(2'b01));
    win(); #1;
    chk("C_grant_on_insert", 64'({gnt0, spi_cs_n}), 64'(2'b10));

    // Owner never offers a byte: forced release after TIMEOUT idle cycles.
    n = 0;
    while (gnt0 && n < 40) begin
      n++;
      win(); #1;
    end
    chk("B_idle_owner_cycles", 64'(n), 64'(16));
    chk("B_timeout_abort", 64'({abort1, abort0, gnt0, spi_cs_n}), 64'(4'b0101));

    // Both requesting after requester 0 held the bus: requester 1 wins.
    win(); req1 = 1'b1; #1;
    n = 0;
    while (!(gnt0 || gnt1) && n < 40) begin
      n++;
      win(); #1;
    end
    chk("D_alternate_to_1", 64'({gnt1, gnt0}), 64'(2'b10));

    // Requester 0 regains the bus, a byte goes out, then reset lands mid-transfer.
    win(); req1 = 1'b0; #1;
    n = 0;
    while (!gnt0 && n < 40) begin
      n++;
      win(); #1;
    end
    chk("E_regrant_0", 64'(gnt0), 64'(1'b1));
    tx_valid0 = 1'b1; tx_data0 = 8'hC3; spi_tx_ready = 1'b1;
    win(); #1;
    chk("E_inflight_blocks", 64'({gnt0, spi_tx_valid, tx_ready0}), 64'(3'b100));
    rst_state = 1'b1; #1;
    chk("E_async_reset", 64'({gnt1, gnt0, spi_cs_n, spi_tx_valid, tx_ready1, tx_ready0, rx_valid1, rx_valid0, abort1, abort0}),
        64'(10'b0010000000));
    win();
    rst_state = 1'b0; tx_valid0 = 1'b0; spi_tx_ready = 1'b0;
    spi_rx_valid = 1'b1; spi_rx_data = 8'h5C; req1 = 1'b1; #1;
    chk("E_post_reset_quiet", 64'({rx_valid1, rx_valid0, abort1, abort0, gnt1, gnt0}), 64'(6'b000000));
    win(); spi_rx_valid = 1'b0; #1;
    chk("E_first_grant_after_reset", 64'({gnt1, gnt0}), 64'(2'b01));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
